// File: rtl/mem_core_fifo_arb.sv
// rtl/mem_core_fifo_arb.sv - two-requester write arbiter and FIFO-mode sequencer for memory_core
// Define MEM_CORE_ARB_RR_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module mem_core_fifo_arb #(
  parameter int DATA_WIDTH      = 16,
  parameter int OCC_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [OCC_WIDTH-1:0]  cfg_depth,
  input  logic [3:0]            cfg_almost_count,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic                  pop_req,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_valid_out,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [OCC_WIDTH-1:0]  occupancy,
  output logic                  busy,
  output logic                  err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e               state_q, state_d;
  logic [OCC_WIDTH-1:0] depth_q, depth_d;
  logic [OCC_WIDTH-1:0] occ_q, occ_d;
  logic [3:0]           almost_q, almost_d;
  logic [OUT_W-1:0]     outst_q, outst_d;
  logic                 err_q, err_d;

  logic                 can_write, tie_pick1, grant0, grant1;
  logic                 rd_issue, rd_return, spurious;
  logic [OCC_WIDTH-1:0] almost_ext, af_thresh;

`ifdef MEM_CORE_ARB_RR_EN
  // last1_q set means req1 won the previous grant, so req0 takes the next tie.
  logic last1_q, last1_d;
  assign tie_pick1 = ~last1_q;
  always_comb begin
    last1_d = last1_q;
    if (grant1) begin
      last1_d = 1'b1;
    end else if (grant0) begin
      last1_d = 1'b0;
    end
  end
`else
  assign tie_pick1 = 1'b0;
`endif

  assign almost_ext = OCC_WIDTH'(almost_q);
  assign af_thresh  = (depth_q > almost_ext) ? (depth_q - almost_ext) : '0;

  assign full         = (occ_q == depth_q);
  assign empty        = (occ_q == '0);
  assign almost_full  = (occ_q >= af_thresh);
  assign almost_empty = (occ_q <= almost_ext);
  assign occupancy    = occ_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

  assign can_write = (state_q == RUN) && !full;
  assign grant0    = can_write && req0_valid && (!req1_valid || !tie_pick1);
  assign grant1    = can_write && req1_valid && (!req0_valid || tie_pick1);

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign mem_wen     = grant0 || grant1;
  assign mem_data_in = grant0 ? req0_data : (grant1 ? req1_data : '0);

  assign rd_issue  = (state_q != IDLE) && pop_req && !empty &&
                     (outst_q < OUT_W'(MAX_OUTSTANDING));
  assign mem_ren   = rd_issue;
  assign rd_return = mem_valid_out && (outst_q != '0);
  assign spurious  = mem_valid_out && (outst_q == '0);
  assign pop_valid = rd_return;

  always_comb begin
    occ_d    = occ_q;
    outst_d  = outst_q;
    depth_d  = depth_q;
    almost_d = almost_q;
    state_d  = state_q;
    err_d    = err_q || spurious;

    case ({mem_wen, rd_issue})
      2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
      2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
      default: occ_d = occ_q;
    endcase

    case ({rd_issue, rd_return})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_depth == '0) begin
            err_d = 1'b1;
          end else begin
            depth_d  = cfg_depth;
            almost_d = cfg_almost_count;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (cfg_stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the final read has returned, not one cycle later.
        if (occ_d == '0 && outst_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      depth_q  <= OCC_WIDTH'(1);
      almost_q <= '0;
      occ_q    <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
`ifdef MEM_CORE_ARB_RR_EN
      last1_q  <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      depth_q  <= depth_d;
      almost_q <= almost_d;
      occ_q    <= occ_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
`ifdef MEM_CORE_ARB_RR_EN
      last1_q  <= last1_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_core_fifo_arb.sv
// tb/tb_mem_core_fifo_arb.sv - self-checking bench for mem_core_fifo_arb
// Directed vector table, hand sequences and randomized traffic against a cycle model.
module tb_mem_core_fifo_arb;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int MO = 2;
`ifdef MEM_CORE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, cfg_start, cfg_stop;
  logic [OW-1:0] cfg_depth;
  logic [3:0]    cfg_almost_count;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data, mem_data_in;
  logic          pop_req, mem_wen, mem_ren, mem_valid_out, pop_valid;
  logic          full, empty, almost_full, almost_empty, busy, err;
  logic [OW-1:0] occupancy;

  mem_core_fifo_arb #(.DATA_WIDTH(DW), .OCC_WIDTH(OW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_depth(cfg_depth), .cfg_almost_count(cfg_almost_count),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .pop_req(pop_req), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_data_in(mem_data_in), .mem_valid_out(mem_valid_out), .pop_valid(pop_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .occupancy(occupancy), .busy(busy), .err(err)
  );

  typedef struct {
    logic st, sp, r0, r1, pop, mvo;
    logic rdy0, rdy1, wen, ren, pv;
    int   occ;
    logic full, empty, af, ae, busy, err;
  } vec_t;

  typedef struct {
    logic rdy0, rdy1, wen, ren, pv, full, empty, af, ae, busy, err;
    int   occ;
  } obs_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   lat   = 1;
  int   core_q[$];
  obs_t obs;

  // Reference model: architectural state as plain integers
  int m_state, m_depth, m_alm, m_occ, m_out, m_err, m_last;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_depth = 1; m_alm = 0; m_occ = 0; m_out = 0; m_err = 0; m_last = 1;
    core_q.delete();
  endtask

  task automatic drive_idle();
    cfg_start = 0; cfg_stop = 0; cfg_depth = '0; cfg_almost_count = '0;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
    pop_req = 0; mem_valid_out = 0;
  endtask

  task automatic core_drive();
    mem_valid_out = 1'b0;
    if (core_q.size() > 0 && core_q[0] <= cyc) begin
      mem_valid_out = 1'b1;
      void'(core_q.pop_front());
    end
  endtask

  // Caller sets inputs at a negedge; this checks mid-cycle, advances the model and returns at the next negedge.
  task automatic step();
    int thr, win, e_ren, e_pv, e_full, e_empty, e_data, spur;
    #1;
    obs.rdy0 = req0_ready; obs.rdy1 = req1_ready; obs.wen = mem_wen; obs.ren = mem_ren;
    obs.pv = pop_valid; obs.full = full; obs.empty = empty; obs.af = almost_full;
    obs.ae = almost_empty; obs.busy = busy; obs.err = err; obs.occ = int'(occupancy);

    e_full  = (m_occ == m_depth);
    e_empty = (m_occ == 0);
    thr     = (m_depth > m_alm) ? m_depth - m_alm : 0;
    win     = -1;
    if (m_state == 1 && !e_full) begin
      if (req0_valid && req1_valid) win = RR ? ((m_last == 0) ? 1 : 0) : 0;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    e_ren  = (m_state != 0 && pop_req && !e_empty && m_out < MO) ? 1 : 0;
    e_pv   = (mem_valid_out && m_out > 0) ? 1 : 0;
    spur   = (mem_valid_out && m_out == 0) ? 1 : 0;
    e_data = (win == 0) ? int'(req0_data) : (win == 1) ? int'(req1_data) : 0;

    chk("m_req0_ready", req0_ready, (win == 0) ? 1 : 0);
    chk("m_req1_ready", req1_ready, (win == 1) ? 1 : 0);
    chk("m_mem_wen", mem_wen, (win >= 0) ? 1 : 0);
    chk("m_mem_data_in", int'(mem_data_in), e_data);
    chk("m_mem_ren", mem_ren, e_ren);
    chk("m_pop_valid", pop_valid, e_pv);
    chk("m_occupancy", int'(occupancy), m_occ);
    chk("m_full", full, e_full);
    chk("m_empty", empty, e_empty);
    chk("m_almost_full", almost_full, (m_occ >= thr) ? 1 : 0);
    chk("m_almost_empty", almost_empty, (m_occ <= m_alm) ? 1 : 0);
    chk("m_busy", busy, (m_state != 0) ? 1 : 0);
    chk("m_err", err, m_err);

    if (e_ren) core_q.push_back(cyc + lat);
    m_occ = m_occ + ((win >= 0) ? 1 : 0) - e_ren;
    m_out = m_out + e_ren - e_pv;
    if (spur || (m_state == 0 && cfg_start && cfg_depth == 0)) m_err = 1;
    if (win >= 0) m_last = win;
    if (m_state == 0 && cfg_start && cfg_depth != 0) begin
      m_state = 1; m_depth = int'(cfg_depth); m_alm = int'(cfg_almost_count);
    end else if (m_state == 1 && cfg_stop) begin
      m_state = 2;
    end else if (m_state == 2 && m_occ == 0 && m_out == 0) begin
      m_state = 0;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  vec_t tv[20];

  initial begin
    tv[0]  = '{1,0,0,0,0,0, 0,0,0,0,0, 0, 0,1,0,1,0,0};
    tv[1]  = '{0,0,1,0,0,0, 1,0,1,0,0, 0, 0,1,0,1,1,0};
    tv[2]  = '{0,0,1,0,0,0, 1,0,1,0,0, 1, 0,0,0,1,1,0};
    tv[3]  = '{0,0,1,0,0,0, 1,0,1,0,0, 2, 0,0,0,0,1,0};
    tv[4]  = '{0,0,1,0,0,0, 1,0,1,0,0, 3, 0,0,1,0,1,0};
    tv[5]  = '{0,0,1,0,0,0, 0,0,0,0,0, 4, 1,0,1,0,1,0};
    tv[6]  = '{0,0,1,1,1,0, 0,0,0,1,0, 4, 1,0,1,0,1,0};
    tv[7]  = '{0,0,1,0,1,0, 1,0,1,1,0, 3, 0,0,1,0,1,0};
    tv[8]  = '{0,0,0,0,1,0, 0,0,0,0,0, 3, 0,0,1,0,1,0};
    tv[9]  = '{0,0,0,0,1,1, 0,0,0,0,1, 3, 0,0,1,0,1,0};
    tv[10] = '{0,0,0,0,1,0, 0,0,0,1,0, 3, 0,0,1,0,1,0};
    tv[11] = '{0,0,0,0,0,1, 0,0,0,0,1, 2, 0,0,0,0,1,0};
    tv[12] = '{0,0,0,0,0,1, 0,0,0,0,1, 2, 0,0,0,0,1,0};
    tv[13] = '{0,0,0,0,0,1, 0,0,0,0,0, 2, 0,0,0,0,1,0};
    tv[14] = '{0,1,0,0,0,0, 0,0,0,0,0, 2, 0,0,0,0,1,1};
    tv[15] = '{0,0,1,0,1,0, 0,0,0,1,0, 2, 0,0,0,0,1,1};
    tv[16] = '{0,0,0,0,1,0, 0,0,0,1,0, 1, 0,0,0,1,1,1};
    tv[17] = '{0,0,0,0,1,1, 0,0,0,0,1, 0, 0,1,0,1,1,1};
    tv[18] = '{0,0,0,0,0,1, 0,0,0,0,1, 0, 0,1,0,1,1,1};
    tv[19] = '{0,0,1,0,1,0, 0,0,0,0,0, 0, 0,1,0,1,0,1};

    reset = 1'b0;
    drive_idle();
    @(negedge clk);
    do_reset();

    // Reset state
    step();
    chk("rst_empty", obs.empty, 1);
    chk("rst_almost_empty", obs.ae, 1);
    chk("rst_full", obs.full, 0);
    chk("rst_busy", obs.busy, 0);
    chk("rst_err", obs.err, 0);
    chk("rst_occupancy", obs.occ, 0);

    // Directed table: fill to full, read throttling, spurious return, drain
    for (int i = 0; i < 20; i++) begin
      cfg_start = tv[i].st; cfg_stop = tv[i].sp; cfg_depth = 16'd4; cfg_almost_count = 4'd1;
      req0_valid = tv[i].r0; req1_valid = tv[i].r1;
      req0_data = DW'(16'h1000 + i); req1_data = DW'(16'h2000 + i);
      pop_req = tv[i].pop; mem_valid_out = tv[i].mvo;
      step();
      chk("tv_req0_ready", obs.rdy0, tv[i].rdy0);
      chk("tv_req1_ready", obs.rdy1, tv[i].rdy1);
      chk("tv_mem_wen", obs.wen, tv[i].wen);
      chk("tv_mem_ren", obs.ren, tv[i].ren);
      chk("tv_pop_valid", obs.pv, tv[i].pv);
      chk("tv_occupancy", obs.occ, tv[i].occ);
      chk("tv_full", obs.full, tv[i].full);
      chk("tv_empty", obs.empty, tv[i].empty);
      chk("tv_almost_full", obs.af, tv[i].af);
      chk("tv_almost_empty", obs.ae, tv[i].ae);
      chk("tv_busy", obs.busy, tv[i].busy);
      chk("tv_err", obs.err, tv[i].err);
    end

    // Tie between requesters, depth 8
    do_reset();
    cfg_start = 1; cfg_depth = 16'd8; cfg_almost_count = 4'd2;
    step();
    cfg_start = 0;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_data = DW'(16'hA000 + i); req1_data = DW'(16'hB000 + i);
      step();
      chk("tie_req1_ready", obs.rdy1, RR ? (i % 2) : 0);
      chk("tie_mem_wen", obs.wen, 1);
    end
    drive_idle();
    step();
    chk("tie_occupancy", obs.occ, 4);

    // Start with zero depth stays idle and flags an error
    do_reset();
    cfg_start = 1; cfg_depth = '0;
    step();
    cfg_start = 0;
    step();
    chk("zdepth_busy", obs.busy, 0);
    chk("zdepth_err", obs.err, 1);

    // Randomized traffic, with reset between epochs and a varying core latency
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      lat = $urandom_range(1, 4);
      cfg_start = 1; cfg_depth = OW'($urandom_range(1, 8)); cfg_almost_count = 4'($urandom_range(0, 15));
      step();
      for (int c = 0; c < 600; c++) begin
        cfg_start        = ($urandom_range(0, 39) == 0);
        cfg_stop         = ($urandom_range(0, 59) == 0);
        cfg_depth        = OW'($urandom_range(0, 8));
        cfg_almost_count = 4'($urandom_range(0, 15));
        req0_valid       = $urandom_range(0, 1);
        req1_valid       = $urandom_range(0, 1);
        req0_data        = DW'($urandom);
        req1_data        = DW'($urandom);
        pop_req          = $urandom_range(0, 1);
        core_drive();
        if (ep == 3 && c == 300) mem_valid_out = 1'b1;
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
